// File: rtl/vga_pattern_sequencer.sv
// rtl/vga_pattern_sequencer.sv - frame-rate pattern mode sequencer with fade-out/switch/fade-in transitions
// Optional feature macro: VGA_SEQ_RANDOM_EN (LFSR-chosen targets for auto transitions).
module vga_pattern_sequencer #(
    parameter int NUM_MODES        = 8,
    parameter int DWELL_FRAMES     = 120,
    parameter int FADE_STEP_FRAMES = 4,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       auto_en,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       hold,
    output logic [2:0] mode,
    output logic [1:0] fade,
    output logic       frame_tick,
    output logic       mode_changed,
    output logic       busy
);
    typedef enum logic [1:0] {SHOW, FADE_OUT, SWITCH, FADE_IN} state_t;

    localparam logic [2:0] MODE_LAST  = 3'(NUM_MODES - 1);
    localparam logic [9:0] DWELL_LAST = 10'(DWELL_FRAMES - 1);
    localparam logic [3:0] STEP_LAST  = 4'(FADE_STEP_FRAMES - 1);

    state_t     state_q;
    logic       vs_s1_q, vs_s2_q, vs_prev_q;
    logic       nx_s1_q, nx_s2_q, nx_smp_q;
    logic       pv_s1_q, pv_s2_q, pv_smp_q;
    logic       req_q, req_dir_q, dir_q;
    logic [9:0] dwell_q;
    logic [3:0] step_q;
    logic [2:0] mode_q;
    logic [1:0] fade_q;
    logic       tick_q, changed_q, busy_q;
    logic       vs_edge_d, nx_rise_d, pv_rise_d;
    logic [2:0] mode_inc, mode_dec, mode_d;
`ifdef VGA_SEQ_RANDOM_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       rnd_q;
    logic [2:0] cand;
`endif

    // Direction encoding: 0 = +1 (next), 1 = -1 (prev).
    always_comb begin
        vs_edge_d = VSYNC_ACTIVE_LOW ? (vs_prev_q & ~vs_s2_q) : (~vs_prev_q & vs_s2_q);
        nx_rise_d = tick_q & nx_s2_q & ~nx_smp_q;
        pv_rise_d = tick_q & pv_s2_q & ~pv_smp_q;
        mode_inc  = (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
        mode_dec  = (mode_q == 3'd0) ? MODE_LAST : mode_q - 3'd1;
`ifdef VGA_SEQ_RANDOM_EN
        lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        cand   = 3'(32'(lfsr_q[2:0]) % NUM_MODES);
        if (rnd_q) begin
            mode_d = (cand == mode_q) ? mode_inc : cand;
        end else begin
            mode_d = dir_q ? mode_dec : mode_inc;
        end
`else
        mode_d = dir_q ? mode_dec : mode_inc;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SHOW;
            vs_s1_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            vs_prev_q <= 1'b0;
            nx_s1_q   <= 1'b0;
            nx_s2_q   <= 1'b0;
            nx_smp_q  <= 1'b0;
            pv_s1_q   <= 1'b0;
            pv_s2_q   <= 1'b0;
            pv_smp_q  <= 1'b0;
            req_q     <= 1'b0;
            req_dir_q <= 1'b0;
            dir_q     <= 1'b0;
            dwell_q   <= '0;
            step_q    <= '0;
            mode_q    <= '0;
            fade_q    <= '0;
            tick_q    <= 1'b0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef VGA_SEQ_RANDOM_EN
            lfsr_q    <= 8'hA5;
            rnd_q     <= 1'b0;
`endif
        end else begin
            vs_s1_q   <= vsync;
            vs_s2_q   <= vs_s1_q;
            vs_prev_q <= vs_s2_q;
            nx_s1_q   <= btn_next;
            nx_s2_q   <= nx_s1_q;
            pv_s1_q   <= btn_prev;
            pv_s2_q   <= pv_s1_q;
            tick_q    <= vs_edge_d;
            changed_q <= 1'b0;

            case (state_q)
                SHOW: begin
                    if (tick_q) begin
                        if (req_q) begin
                            dir_q   <= req_dir_q;
                            step_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= FADE_OUT;
`ifdef VGA_SEQ_RANDOM_EN
                            rnd_q   <= 1'b0;
`endif
                        end else if (auto_en && !hold) begin
                            if (dwell_q == DWELL_LAST) begin
                                dwell_q <= '0;
                                dir_q   <= 1'b0;
                                step_q  <= '0;
                                busy_q  <= 1'b1;
                                state_q <= FADE_OUT;
`ifdef VGA_SEQ_RANDOM_EN
                                rnd_q   <= 1'b1;
`endif
                            end else begin
                                dwell_q <= dwell_q + 10'd1;
                            end
                        end
                    end
                end
                FADE_OUT: begin
                    if (tick_q) begin
                        if (step_q == STEP_LAST) begin
                            step_q <= '0;
                            if (fade_q == 2'd3) begin
                                state_q <= SWITCH;
                            end else begin
                                fade_q <= fade_q + 2'd1;
                            end
                        end else begin
                            step_q <= step_q + 4'd1;
                        end
                    end
                end
                SWITCH: begin
                    mode_q    <= mode_d;
                    changed_q <= 1'b1;
                    step_q    <= '0;
                    state_q   <= FADE_IN;
                end
                FADE_IN: begin
                    if (tick_q) begin
                        if (step_q == STEP_LAST) begin
                            step_q <= '0;
                            fade_q <= fade_q - 2'd1;
                            if (fade_q == 2'd1) begin
                                dwell_q <= '0;
                                busy_q  <= 1'b0;
                                state_q <= SHOW;
                            end
                        end else begin
                            step_q <= step_q + 4'd1;
                        end
                    end
                end
                default: state_q <= SHOW;
            endcase

            // Buttons are only looked at once per frame, which debounces them.
            if (tick_q) begin
                nx_smp_q <= nx_s2_q;
                pv_smp_q <= pv_s2_q;
`ifdef VGA_SEQ_RANDOM_EN
                lfsr_q   <= lfsr_d;
`endif
                if (nx_rise_d != pv_rise_d) begin
                    req_q     <= 1'b1;
                    req_dir_q <= pv_rise_d;
                end else if (state_q == SHOW && req_q) begin
                    req_q <= 1'b0;
                end
            end
        end
    end

    assign mode         = mode_q;
    assign fade         = fade_q;
    assign frame_tick   = tick_q;
    assign mode_changed = changed_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// tb/tb_vga_pattern_sequencer.sv - self-checking bench for vga_pattern_sequencer against a frame-level model
module tb_vga_pattern_sequencer;
    localparam int N = 5;
    localparam int D = 3;
    localparam int F = 2;
`ifdef VGA_SEQ_RANDOM_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, vsync, auto_en, btn_next, btn_prev, hold;
    logic [2:0] mode;
    logic [1:0] fade;
    logic       frame_tick, mode_changed, busy;

    int total = 0;
    int bad = 0;
    int tick_cnt = 0;
    int mc_cnt = 0;

    // Frame-level model: phase 0 = showing, 1 = fading out, 2 = fading in.
    int       m_mode, m_fade, m_phase, m_dwell, m_k, m_dir, m_pdir, m_changes;
    bit       m_pend, m_pn, m_pp, m_rnd;
    logic [7:0] m_lfsr;

    vga_pattern_sequencer #(
        .NUM_MODES(N), .DWELL_FRAMES(D), .FADE_STEP_FRAMES(F), .VSYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .auto_en(auto_en),
        .btn_next(btn_next), .btn_prev(btn_prev), .hold(hold),
        .mode(mode), .fade(fade), .frame_tick(frame_tick),
        .mode_changed(mode_changed), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_tick) tick_cnt++;
        if (mode_changed) mc_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_fade = 0; m_phase = 0; m_dwell = 0; m_k = 0;
        m_dir = 1; m_pdir = 1; m_pend = 0; m_pn = 0; m_pp = 0; m_rnd = 0;
        m_lfsr = 8'hA5;
    endtask

    task automatic model_tick(input bit n, input bit p, input bit a, input bit h);
        bit rn, rp, serve;
        int cand;
        serve = 0;
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
        case (m_phase)
            0: begin
                if (m_pend) begin
                    m_dir = m_pdir; m_rnd = 0; serve = 1; m_phase = 1; m_k = 0;
                end else if (a && !h) begin
                    if (m_dwell == D - 1) begin
                        m_dwell = 0; m_dir = 1; m_rnd = 1; m_phase = 1; m_k = 0;
                    end else begin
                        m_dwell++;
                    end
                end
            end
            1: begin
                m_k++;
                m_fade = (m_k / F > 3) ? 3 : m_k / F;
                if (m_k == 4 * F) begin
                    cand = (m_mode + m_dir + N) % N;
                    if (RND && m_rnd) begin
                        cand = (m_lfsr % 8) % N;
                        if (cand == m_mode) cand = (m_mode + 1) % N;
                    end
                    m_mode = cand; m_changes++; m_phase = 2; m_k = 0;
                end
            end
            default: begin
                m_k++;
                m_fade = 3 - m_k / F;
                if (m_k == 3 * F) begin
                    m_phase = 0; m_dwell = 0;
                end
            end
        endcase
        if (serve) m_pend = 0;
        rn = n && !m_pn;
        rp = p && !m_pp;
        if (rn != rp) begin
            m_pend = 1; m_pdir = rn ? 1 : -1;
        end
        m_pn = n; m_pp = p;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; vsync = 1'b1; auto_en = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mode", mode, 0);
        chk("rst_fade", fade, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", frame_tick, 0);
        chk("rst_changed", mode_changed, 0);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
    endtask

    // One vsync frame: set inputs, pulse vsync low, step the model once and compare.
    task automatic run_frame(input bit n, input bit p, input bit a, input bit h);
        int t0, c0, e0;
        logic [2:0] ft;
        logic [2:0] pmode;
        btn_next = n; btn_prev = p; auto_en = a; hold = h;
        pmode = mode;
        repeat (4) @(posedge clk);
        t0 = tick_cnt; c0 = mc_cnt; e0 = m_changes;
        #1 vsync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            ft[2 - i] = frame_tick;
        end
        vsync = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        model_tick(n, p, a, h);
        chk("tick_latency", {29'd0, ft}, 3'b001);
        chk("tick_count", tick_cnt - t0, 1);
        chk("changed_count", mc_cnt - c0, m_changes - e0);
        chk("mode", mode, m_mode);
        chk("fade", fade, m_fade);
        chk("busy", busy, (m_phase != 0) ? 1 : 0);
        if (mc_cnt != c0) chk("no_repeat", (mode != pmode) ? 1 : 0, 1);
    endtask

    initial begin
        int c0;
        bit rn, rp, ra, rh;
        m_changes = 0;
        model_reset();

        // Auto dwell/fade cycling.
        do_reset();
        for (int i = 0; i < 20; i++) run_frame(0, 0, 1, 0);

        // Previous from mode 0 wraps to NUM_MODES-1.
        do_reset();
        c0 = mc_cnt;
        run_frame(0, 1, 0, 0);
        for (int i = 0; i < 16; i++) run_frame(0, 0, 0, 0);
        chk("prev_wrap_mode", mode, N - 1);
        chk("prev_wrap_changes", mc_cnt - c0, 1);

        // Held button gives exactly one transition.
        c0 = mc_cnt;
        for (int i = 0; i < 10; i++) run_frame(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) run_frame(0, 0, 0, 0);
        chk("held_next_changes", mc_cnt - c0, 1);
        chk("held_next_mode", mode, 0);

        // Both buttons rising together are discarded.
        c0 = mc_cnt;
        run_frame(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) run_frame(0, 0, 0, 0);
        chk("both_changes", mc_cnt - c0, 0);

        // Request during fade-in queues a second transition.
        c0 = mc_cnt;
        run_frame(1, 0, 0, 0);
        for (int i = 0; i < 20 && m_phase != 2; i++) run_frame(0, 0, 0, 0);
        run_frame(1, 0, 0, 0);
        for (int i = 0; i < 25; i++) run_frame(0, 0, 0, 0);
        chk("queued_changes", mc_cnt - c0, 2);

        // Hold freezes dwell: switch lands 5 frames later (frame 16 instead of 11).
        do_reset();
        c0 = mc_cnt;
        run_frame(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) run_frame(0, 0, 1, 1);
        for (int i = 0; i < 9; i++) run_frame(0, 0, 1, 0);
        chk("hold_not_yet", mc_cnt - c0, 0);
        run_frame(0, 0, 1, 0);
        chk("hold_switch", mc_cnt - c0, 1);

        // Randomised inputs.
        rn = 0; rp = 0; ra = 1; rh = 0;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) rn = ~rn;
            if ($urandom_range(0, 4) == 0) rp = ~rp;
            if (i % 30 == 0) ra = 1'($urandom_range(0, 1));
            rh = ($urandom_range(0, 4) == 0);
            run_frame(rn, rp, ra, rh);
        end

        // Asynchronous reset in the middle of a fade-out.
        do_reset();
        for (int i = 0; i < 80 && !(m_phase == 1 && m_fade == 2 && m_mode != 0); i++)
            run_frame(0, 0, 1, 0);
        chk("pre_rst_fade", fade, 2);
        chk("pre_rst_mode_nonzero", (mode != 0) ? 1 : 0, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_mode", mode, 0);
        chk("async_rst_fade", fade, 0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
